mem_loader: RTL and testbench
=============================

# mem_loader

Initiator-side loader for the 64-word, word-addressed memories used in the core: it accepts a byte stream, packs bytes little-endian into 32-bit words, and writes them to consecutive addresses through a single write port (write enable, address, write data, combinational read data). After loading, it reads every written word back, recomputes the sum and flags any mismatch against the sum taken at write time. It sits between a byte source (host link or boot ROM streamer) and the data/instruction memory write port.

## Interface
- ADDR_W, 6, memory address width; depth is 2**ADDR_W words
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a load; sampled only in IDLE or DONE
- word_count  in  ADDR_W+1  number of words to load; sampled with start
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte this cycle
- mem_write_en  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory word address
- mem_write_data  out  32  word to write
- mem_read_data  in  32  combinational read data for mem_addr
- busy  out  1  high in LOAD, WRITE, VERIFY
- done  out  1  high in DONE
- error  out  1  readback sum mismatch; valid while done=1
- checksum  out  32  sum of written words mod 2**32

## Operation
- States: IDLE, LOAD, WRITE, VERIFY, DONE.
- IDLE/DONE + start=1: latch n = min(word_count, 2**ADDR_W); clear word index, byte index, checksum, verify sum, error, done. n=0 -> DONE next cycle, no writes, error=0. Otherwise -> LOAD.
- start while busy: ignored.
- LOAD: in_ready=1. Byte accepted when in_valid && in_ready. Byte k (0..3) goes to word bits [8k+7:8k]. The 4th accepted byte -> WRITE.
- WRITE (one cycle): in_ready=0, mem_write_en=1, mem_addr=word index, mem_write_data=packed word. Checksum += word. Word index increments. Last word (index n-1) -> VERIFY with verify address 0. Otherwise -> LOAD.
- VERIFY: mem_write_en=0, mem_addr=verify address. Each cycle, verify sum += mem_read_data and address increments. After n reads -> DONE with error = (verify sum incl. last read != checksum).
- DONE: done=1, error and checksum held until the next accepted start.
- Arithmetic: all sums are 32-bit and wrap mod 2**32. Addresses never exceed n-1, so there is no address wrap.
- Reset mid-operation: every register returns to its reset value and the state goes to IDLE. Words already written stay in memory and are not rewritten.

## Timing
- Reset values: in_ready=0, mem_write_en=0, mem_addr=0, mem_write_data=0, busy=0, done=0, error=0, checksum=0, state IDLE.
- All outputs are registered or decoded from registered state only; there is no combinational path from in_valid or mem_read_data to any output.
- start -> LOAD (busy=1, in_ready=1) on the next cycle.
- Minimum 5 cycles per word: 4 byte handshakes + 1 WRITE cycle. in_ready drops for exactly the WRITE cycle.
- The WRITE cycle follows the 4th byte handshake directly, and the write commits on that cycle's rising edge at the memory.
- VERIFY takes exactly n cycles, then done=1 on the following cycle.
- Total for n words with no stalls: 1 + 5n + n cycles from start to done.
- in_valid with in_ready=0: byte is not consumed, and the source must hold it.

## Test plan
- Single word: word_count=1, bytes 0x78,0x56,0x34,0x12 back-to-back -> one write, addr 0, data 0x12345678; checksum=0x12345678; done=1 at cycle 7 after start; error=0.
- Full depth: word_count=64, word i = i -> writes addr 0..63, last write at addr 63, checksum=0x000007E0, error=0; word_count=100 -> identical result (clamped to 64).
- Backpressure/gaps: same single word with in_valid low for random 0-3 cycles between bytes -> identical write and checksum; no byte is lost or duplicated, and in_ready=0 during WRITE.
- Corruption: memory model returns addr 2 data XOR 0x1 on read, word_count=4 -> writes correct, done=1, error=1.
- Degenerate/ignored: word_count=0 -> done the next cycle, mem_write_en never asserted; start pulsed during LOAD -> no effect on index or checksum.
- Reset mid-load: rst_n low after 2 words written -> all outputs at reset values immediately; new start with word_count=1 writes addr 0 and checksum restarts from 0.

Source files
------------

// File: rtl/mem_loader.sv
// mem_loader: packs a byte stream into words, writes them, then reads back and verifies the sum.
// Ports: start/word_count, in_valid/in_data/in_ready, mem_* port, busy/done/error/checksum.
module mem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE, LOAD, WRITE, VERIFY, DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W:0]   n_q;
  logic [ADDR_W:0]   n_lat;
  logic [ADDR_W-1:0] widx;
  logic [ADDR_W-1:0] vaddr;
  logic [1:0]        bidx;
  logic [31:0]       word_q;
  logic [31:0]       vsum;
  logic [31:0]       vsum_nx;
  logic              go;
  logic              acc;
  logic              last_w;
  logic              last_v;

  assign go      = start && (state == IDLE || state == DONE);
  assign acc     = in_valid && (state == LOAD);
  assign n_lat   = (word_count > DEPTH) ? DEPTH : word_count;
  assign last_w  = ({1'b0, widx} == n_q - (ADDR_W+1)'(1));
  assign last_v  = ({1'b0, vaddr} == n_q - (ADDR_W+1)'(1));
  assign vsum_nx = vsum + mem_read_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      n_q      <= '0;
      widx     <= '0;
      vaddr    <= '0;
      bidx     <= '0;
      word_q   <= '0;
      vsum     <= '0;
      checksum <= '0;
      error    <= 1'b0;
    end else begin
      state <= state_nx;
      if (go) begin
        n_q      <= n_lat;
        widx     <= '0;
        vaddr    <= '0;
        bidx     <= '0;
        word_q   <= '0;
        vsum     <= '0;
        checksum <= '0;
        error    <= 1'b0;
      end
      if (acc) begin
        word_q[{bidx, 3'b000} +: 8] <= in_data;
        bidx <= bidx + 2'd1;
      end
      if (state == WRITE) begin
        checksum <= checksum + word_q;
        widx     <= widx + ADDR_W'(1);
        vaddr    <= '0;
      end
      if (state == VERIFY) begin
        vsum  <= vsum_nx;
        vaddr <= vaddr + ADDR_W'(1);
        // Compare including the read taken on this final cycle.
        if (last_v) error <= (vsum_nx != checksum);
      end
    end
  end

  always_comb begin
    state_nx       = state;
    in_ready       = 1'b0;
    mem_write_en   = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    busy           = 1'b0;
    done           = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_nx = (n_lat == '0) ? DONE : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && bidx == 2'd3) state_nx = WRITE;
      end
      WRITE: begin
        busy           = 1'b1;
        mem_write_en   = 1'b1;
        mem_addr       = widx;
        mem_write_data = word_q;
        state_nx       = last_w ? VERIFY : LOAD;
      end
      VERIFY: begin
        busy     = 1'b1;
        mem_addr = vaddr;
        if (last_v) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: table-driven and randomized checks of mem_loader
// against a word-list reference model and a behavioural memory.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  word_count = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        mem_write_en;
  logic [5:0]  mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;

  always #5 clk = ~clk;

  mem_loader #(.ADDR_W(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .word_count(word_count),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .mem_write_en(mem_write_en),
    .mem_addr(mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .busy(busy),
    .done(done),
    .error(error),
    .checksum(checksum)
  );

  logic [31:0] mem [64];
  logic        corrupt_on = 1'b0;
  logic [5:0]  caddr = '0;
  int          wlog_a[$];
  logic [31:0] wlog_d[$];

  assign mem_read_data = mem[mem_addr] ^
    {31'd0, corrupt_on && (mem_addr == caddr)};

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_addr] <= mem_write_data;
      wlog_a.push_back(int'(mem_addr));
      wlog_d.push_back(mem_write_data);
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  logic [7:0]  src[$];
  logic [31:0] exp_w[64];
  logic [31:0] model_sum;

  task automatic fill_pat(input int pat);
    src.delete();
    if (pat == 0) begin
      src.push_back(8'h78); src.push_back(8'h56);
      src.push_back(8'h34); src.push_back(8'h12);
    end else if (pat == 1) begin
      for (int i = 0; i < 64; i++) begin
        src.push_back(8'(i)); src.push_back(8'h00);
        src.push_back(8'h00); src.push_back(8'h00);
      end
    end else begin
      for (int i = 0; i < 256; i++) src.push_back(8'($urandom));
    end
  endtask

  // Reference: words are little-endian groups of four stream bytes.
  task automatic build_model(input int n);
    model_sum = 0;
    for (int i = 0; i < n; i++) begin
      exp_w[i] = {src[4*i+3], src[4*i+2], src[4*i+1], src[4*i]};
      model_sum = model_sum + exp_w[i];
    end
  endtask

  task automatic run(input logic [6:0] wc, input bit gaps,
                     input bit pulse, input int abort_w,
                     output int cyc, output bit got, output int viol);
    int idx, gap, bound;
    bit hs;
    bound = 400 + 30 * ((wc > 64) ? 64 : int'(wc));
    wlog_a.delete(); wlog_d.delete();
    @(negedge clk);
    start = 1'b1; word_count = wc; in_valid = 1'b0;
    cyc = 0; idx = 0; got = 0; viol = 0; hs = 0;
    gap = gaps ? int'($urandom_range(3)) : 0;
    while (cyc < bound) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; word_count = '0;
      if (hs) begin
        idx++;
        gap = gaps ? int'($urandom_range(3)) : 0;
      end
      if (mem_write_en && in_ready) viol++;
      if (done) begin got = 1; break; end
      if (abort_w > 0 && wlog_a.size() >= abort_w) begin
        rst_n = 1'b0; in_valid = 1'b0; got = 1; break;
      end
      if (pulse && cyc == 2) begin start = 1'b1; word_count = 7'd1; end
      if (gap > 0) begin
        in_valid = 1'b0; gap--;
      end else if (idx < src.size()) begin
        in_valid = 1'b1; in_data = src[idx];
      end else begin
        in_valid = 1'b0;
      end
      hs = in_valid && in_ready;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [6:0] wc,
                           input bit gaps, input bit pulse,
                           input logic [31:0] e_sum, input bit e_err,
                           input int e_cyc);
    int n, cyc, viol;
    bit got;
    n = (wc > 64) ? 64 : int'(wc);
    build_model(n);
    run(wc, gaps, pulse, 0, cyc, got, viol);
    check({tag, "_done_reached"}, 32'(got), 32'd1);
    if (e_cyc >= 0) check({tag, "_cycles"}, 32'(cyc), 32'(e_cyc));
    check({tag, "_checksum"}, checksum, e_sum);
    check({tag, "_error"}, 32'(error), 32'(e_err));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_nwrites"}, 32'(wlog_a.size()), 32'(n));
    check({tag, "_ready_in_write"}, 32'(viol), 32'd0);
    for (int i = 0; i < n && i < wlog_a.size(); i++) begin
      check($sformatf("%s_wr%0d_addr", tag, i), 32'(wlog_a[i]), 32'(i));
      check($sformatf("%s_wr%0d_data", tag, i), wlog_d[i], exp_w[i]);
      check($sformatf("%s_mem%0d", tag, i), mem[i], exp_w[i]);
    end
  endtask

  typedef struct {
    logic [6:0]  wc;
    int          pat;
    bit          gaps;
    bit          corrupt;
    bit          pulse;
    logic [31:0] exp_sum;
    bit          exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cyc, viol, n;
    bit got, cerr;

    vecs[0] = '{7'd1,   0, 0, 0, 0, 32'h12345678, 0, 7};
    vecs[1] = '{7'd1,   0, 1, 0, 0, 32'h12345678, 0, -1};
    vecs[2] = '{7'd64,  1, 0, 0, 0, 32'h000007E0, 0, 385};
    vecs[3] = '{7'd100, 1, 0, 0, 0, 32'h000007E0, 0, 385};
    vecs[4] = '{7'd4,   1, 0, 1, 0, 32'h00000006, 1, 25};
    vecs[5] = '{7'd0,   0, 0, 0, 0, 32'h00000000, 0, 1};
    vecs[6] = '{7'd4,   1, 0, 0, 1, 32'h00000006, 0, 25};

    for (int i = 0; i < 64; i++) mem[i] = '0;

    #12;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_wen", 32'(mem_write_en), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", mem_write_data, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_checksum", checksum, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      fill_pat(vecs[v].pat);
      corrupt_on = vecs[v].corrupt;
      caddr = 6'd2;
      run_check($sformatf("vec%0d", v), vecs[v].wc, vecs[v].gaps,
                vecs[v].pulse, vecs[v].exp_sum, vecs[v].exp_err,
                vecs[v].exp_cyc);
      corrupt_on = 1'b0;
    end

    // Reset after two words have been written.
    fill_pat(1);
    run(7'd4, 0, 0, 2, cyc, got, viol);
    check("abort_reached", 32'(got), 1);
    #1;
    check("abort_in_ready", 32'(in_ready), 0);
    check("abort_wen", 32'(mem_write_en), 0);
    check("abort_addr", 32'(mem_addr), 0);
    check("abort_wdata", mem_write_data, 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_error", 32'(error), 0);
    check("abort_checksum", checksum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    fill_pat(0);
    run_check("after_rst", 7'd1, 0, 0, 32'h12345678, 0, 7);
    check("after_rst_mem1_kept", mem[1], 32'h00000001);

    for (int r = 0; r < 6; r++) begin
      fill_pat(2);
      n = (r == 5) ? int'($urandom_range(60, 127)) : int'($urandom_range(1, 12));
      corrupt_on = 1'($urandom_range(1));
      caddr = 6'($urandom_range(15));
      cerr = corrupt_on && (int'(caddr) < ((n > 64) ? 64 : n));
      build_model((n > 64) ? 64 : n);
      run_check($sformatf("rnd%0d", r), 7'(n), 1'($urandom_range(1)), 0,
                model_sum, cerr, -1);
      corrupt_on = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
